// File: rtl/bc_pkg.sv
// bc_pkg: shared miner widths and the nonce type
package bc_pkg;
  localparam int NONCE_W = 32;
  typedef logic [NONCE_W-1:0] nonce_t;
endpackage

// File: rtl/nonce_buffer_mem.sv
// nonce_buffer_mem: DEPTH x NONCE_W register array, sync write, async read
// ports: clk, rst_n, we/wr_addr/wr_data write port, rd_addr/rd_data read port
module nonce_buffer_mem
  import bc_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NONCE_W = bc_pkg::NONCE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [NONCE_W-1:0]       wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [NONCE_W-1:0]       rd_data
);
  logic [NONCE_W-1:0] mem [DEPTH];
  // cleared on reset so the fall-through head reads 0 straight out of reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/nonce_buffer.sv
// nonce_buffer: non-stalling FIFO of golden nonces with drop counting and flush
// ports: clk, rst_n; wr_valid/wr_nonce from the miner; flush on new block;
//        rd_ready/rd_valid/rd_nonce to the reader; count, full, overflow,
//        drop_count status; clr_overflow clears overflow and drop_count
module nonce_buffer
  import bc_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NONCE_W = bc_pkg::NONCE_W,
  parameter int DROP_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  input  logic [NONCE_W-1:0]         wr_nonce,
  input  logic                       flush,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [NONCE_W-1:0]         rd_nonce,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  input  logic                       clr_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("nonce_buffer: DEPTH must be a power of 2 and >= 2");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic pop, push, drop;
  assign pop     = rd_valid & rd_ready;
  assign push    = wr_valid & (!full | pop);
  assign drop    = wr_valid & full & !pop;
  assign cnt_nxt = count + CW'(push) - CW'(pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_valid   <= 1'b0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      // flush overrides any same-cycle push/pop; status counters survive it
      wr_ptr   <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr   <= flush ? '0 : rd_ptr + AW'(pop);
      count    <= flush ? '0 : cnt_nxt;
      rd_valid <= !flush && cnt_nxt != '0;
      full     <= !flush && cnt_nxt == CW'(DEPTH);
      // a clear wins over a coincident drop; a write lost to flush is not a drop
      overflow   <= clr_overflow ? 1'b0 : overflow | (drop & !flush);
      drop_count <= clr_overflow ? '0 : drop_count + DROP_W'(drop & !flush & ~&drop_count);
    end
  nonce_buffer_mem #(.DEPTH(DEPTH), .NONCE_W(NONCE_W)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (push & !flush),
    .wr_addr (wr_ptr),
    .wr_data (wr_nonce),
    .rd_addr (rd_ptr),
    .rd_data (rd_nonce)
  );
endmodule

// File: tb/tb_nonce_buffer.sv
// tb_nonce_buffer: directed self-checking bench for nonce_buffer
module tb_nonce_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_nonce = '0;
  logic        flush = 1'b0;
  logic        rd_ready = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        rd_valid, full, overflow;
  logic [31:0] rd_nonce;
  logic [3:0]  count;
  logic [7:0]  drop_count;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] q[$];

  nonce_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_nonce     (wr_nonce),
    .flush        (flush),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_nonce     (rd_nonce),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive inputs for one edge, then sample 1ns after it
  task automatic cyc(input logic wv, input logic [31:0] wn, input logic rr,
                     input logic fl, input logic clr);
    wr_valid = wv; wr_nonce = wn; rd_ready = rr; flush = fl; clr_overflow = clr;
    @(posedge clk);
    #1;
    wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0; clr_overflow = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_rd_nonce", rd_nonce, 0);
    rst_n = 1'b1;

    // 1: three writes then ordered readout
    cyc(1, 32'hDEADBEEF, 0, 0, 0);
    chk("t1_valid_after_first", 32'(rd_valid), 1);
    chk("t1_head_first", rd_nonce, 32'hDEADBEEF);
    cyc(1, 32'h00000001, 0, 0, 0);
    cyc(1, 32'hFFFFFFFF, 0, 0, 0);
    chk("t1_count3", 32'(count), 3);
    chk("t1_head0", rd_nonce, 32'hDEADBEEF);
    cyc(0, 0, 1, 0, 0);
    chk("t1_head1", rd_nonce, 32'h00000001);
    chk("t1_count2", 32'(count), 2);
    cyc(0, 0, 1, 0, 0);
    chk("t1_head2", rd_nonce, 32'hFFFFFFFF);
    cyc(0, 0, 1, 0, 0);
    chk("t1_empty", 32'(rd_valid), 0);
    chk("t1_count0", 32'(count), 0);

    // 2: fill 8, three drops, contents are the first 8
    for (int i = 0; i < 8; i++) cyc(1, 32'(100 + i), 0, 0, 0);
    chk("t2_full", 32'(full), 1);
    chk("t2_count8", 32'(count), 8);
    chk("t2_no_ovf_yet", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'(900 + i), 0, 0, 0);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_drop3", 32'(drop_count), 3);
    chk("t2_count_still8", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_head%0d", i), rd_nonce, 32'(100 + i));
      cyc(0, 0, 1, 0, 0);
    end
    chk("t2_empty", 32'(rd_valid), 0);

    // 3: full with simultaneous push/pop for 20 cycles, across wrap
    for (int i = 0; i < 8; i++) begin
      cyc(1, 32'(200 + i), 0, 0, 0);
      q.push_back(32'(200 + i));
    end
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t3_head%0d", i), rd_nonce, q[0]);
      cyc(1, 32'(300 + i), 1, 0, 0);
      void'(q.pop_front());
      q.push_back(32'(300 + i));
      chk($sformatf("t3_count%0d", i), 32'(count), 8);
    end
    chk("t3_full", 32'(full), 1);
    chk("t3_drop_unchanged", 32'(drop_count), 3);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_drain%0d", i), rd_nonce, q.pop_front());
      cyc(0, 0, 1, 0, 0);
    end
    chk("t3_empty", 32'(rd_valid), 0);

    // 4: flush with same-cycle write
    for (int i = 0; i < 5; i++) cyc(1, 32'(400 + i), 0, 0, 0);
    chk("t4_count5", 32'(count), 5);
    cyc(1, 32'h0000AAAA, 1, 1, 0);
    chk("t4_count0", 32'(count), 0);
    chk("t4_rd_valid0", 32'(rd_valid), 0);
    chk("t4_drop_kept", 32'(drop_count), 3);
    chk("t4_ovf_kept", 32'(overflow), 1);
    cyc(1, 32'h00000055, 0, 0, 0);
    chk("t4_count1", 32'(count), 1);
    chk("t4_head_alone", rd_nonce, 32'h00000055);
    cyc(0, 0, 1, 0, 0);
    chk("t4_empty", 32'(rd_valid), 0);

    // 5: saturating drop counter and clear
    for (int i = 0; i < 8; i++) cyc(1, 32'(500 + i), 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, 32'(i), 0, 0, 0);
    chk("t5_sat", 32'(drop_count), 255);
    chk("t5_ovf", 32'(overflow), 1);
    chk("t5_head_kept", rd_nonce, 32'(500));
    cyc(0, 0, 0, 0, 1);
    chk("t5_clr_drop", 32'(drop_count), 0);
    chk("t5_clr_ovf", 32'(overflow), 0);
    cyc(1, 32'h1234, 0, 0, 0);
    chk("t5_one_drop", 32'(drop_count), 1);
    chk("t5_ovf_again", 32'(overflow), 1);
    cyc(1, 32'h5678, 0, 0, 1);
    chk("t5_clr_wins_drop", 32'(drop_count), 0);
    chk("t5_clr_wins_ovf", 32'(overflow), 0);

    // 6: async reset between edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_full", 32'(full), 0);
    chk("t6_rd_valid", 32'(rd_valid), 0);
    chk("t6_overflow", 32'(overflow), 0);
    chk("t6_drop", 32'(drop_count), 0);
    chk("t6_rd_nonce", rd_nonce, 0);
    #10;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
